// File: rtl/arm_mmio_pkg.sv
// Shared register-map offsets and bit positions for the memory-mapped timer.
package arm_mmio_pkg;

  typedef enum logic [1:0] {
    OFF_CTRL   = 2'd0,
    OFF_LOAD   = 2'd1,
    OFF_COUNT  = 2'd2,
    OFF_STATUS = 2'd3
  } reg_off_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_EXP  = 0;

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled clocks; holds while disabled.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  assign tick = en & (r_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (en)     r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: bus decode, CTRL/LOAD/COUNT/STATUS registers,
// countdown on prescaler ticks, combinational read mux and level interrupt.
module mmio_timer
  import arm_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        irq
);

  reg_off_e    w_off;
  logic        w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
  logic        w_tick, w_clr, w_expire;
  logic [2:0]  r_ctrl;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_exp;

  assign sel   = (a[31:4] == BASE_ADDR[31:4]);
  assign w_off = reg_off_e'(a[3:2]);

  assign w_wr_ctrl   = we & sel & (w_off == OFF_CTRL);
  assign w_wr_load   = we & sel & (w_off == OFF_LOAD);
  assign w_wr_count  = we & sel & (w_off == OFF_COUNT);
  assign w_wr_status = we & sel & (w_off == OFF_STATUS);

  // Restart the prescaler only on an EN rising write so the first tick is a full period away.
  assign w_clr    = w_wr_ctrl & wd[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_expire = w_tick & (r_count <= 32'd1);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (r_ctrl[CTRL_EN]),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // A CTRL write outranks the one-shot self-disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ctrl <= '0;
    else if (w_wr_ctrl)
      r_ctrl <= wd[2:0];
    else if (w_expire & ~r_ctrl[CTRL_AUTO])
      r_ctrl[CTRL_EN] <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_load <= '0;
    else if (w_wr_load) r_load <= wd;
  end

  // A software COUNT write outranks the tick update in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (w_wr_count)
      r_count <= wd;
    else if (w_expire)
      r_count <= r_ctrl[CTRL_AUTO] ? r_load : '0;
    else if (w_tick)
      r_count <= r_count - 32'd1;
  end

  // Expiry outranks write-one-to-clear so an event landing with the clear is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_exp <= 1'b0;
    else if (w_expire)
      r_exp <= 1'b1;
    else if (w_wr_status & wd[STAT_EXP])
      r_exp <= 1'b0;
  end

  // NOTE: rd gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd = '0;
    if (sel) begin
      unique case (w_off)
        OFF_CTRL:   rd = {29'd0, r_ctrl};
        OFF_LOAD:   rd = r_load;
        OFF_COUNT:  rd = r_count;
        OFF_STATUS: rd = {31'd0, r_exp};
        default:    rd = '0;
      endcase
    end
  end

  assign irq = r_exp & r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: behavioural register-map model compared every
// cycle, plus hand-computed expectations at the key timing points.
module tb_mmio_timer;

  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam int          PRESCALE = 4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_LOAD   = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        irq;

  int total = 0;
  int bad   = 0;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: register values plus the number of enabled cycles since the last tick.
  logic        m_en, m_auto, m_ie, m_exp;
  logic [31:0] m_load, m_count;
  int          m_pre;

  always @(posedge clk or posedge reset) begin : model
    bit          tick, hit;
    int          n_pre;
    logic        n_en, n_auto, n_ie, n_exp;
    logic [31:0] n_load, n_count;
    if (reset) begin
      m_en <= 1'b0; m_auto <= 1'b0; m_ie <= 1'b0; m_exp <= 1'b0;
      m_load <= '0; m_count <= '0; m_pre <= 0;
    end else begin
      tick    = m_en && (m_pre == PRESCALE - 1);
      hit     = we && (a[31:4] == BASE[31:4]);
      n_pre   = m_en ? (tick ? 0 : m_pre + 1) : m_pre;
      n_en    = m_en;   n_auto  = m_auto; n_ie = m_ie;
      n_load  = m_load; n_count = m_count; n_exp = m_exp;
      if (hit && a[3:2] == 2'd3 && wd[0]) n_exp = 1'b0;
      if (tick) begin
        if (m_count > 32'd1) n_count = m_count - 32'd1;
        else begin
          n_exp   = 1'b1;
          n_count = m_auto ? m_load : 32'd0;
          if (!m_auto) n_en = 1'b0;
        end
      end
      if (hit) begin
        case (a[3:2])
          2'd0: begin
            if (wd[0] && !m_en) n_pre = 0;
            n_en = wd[0]; n_auto = wd[1]; n_ie = wd[2];
          end
          2'd1: n_load  = wd;
          2'd2: n_count = wd;
          default: ;
        endcase
      end
      m_en <= n_en; m_auto <= n_auto; m_ie <= n_ie; m_exp <= n_exp;
      m_load <= n_load; m_count <= n_count; m_pre <= n_pre;
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    if (addr[31:4] != BASE[31:4]) return 32'd0;
    case (addr[3:2])
      2'd0:    return {29'd0, m_ie, m_auto, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1 we = 1'b0; wd = '0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1 check(name, rd, exp);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; a = '0; wd = '0;
    fork
      forever begin
        @(negedge clk);
        check("cyc_sel", {31'd0, sel}, {31'd0, a[31:4] == BASE[31:4]});
        check("cyc_rd", rd, m_read(a));
        check("cyc_irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_count", A_COUNT, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Auto-reload, LOAD=3: expiry 12 cycles after CTRL edge and every 12 after.
    wr(A_LOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'd7);
    repeat (11) @(posedge clk);
    rd_check("auto_pre_exp", A_STATUS, 32'd0);
    @(posedge clk);
    rd_check("auto_exp", A_STATUS, 32'd1);
    check("auto_irq", {31'd0, irq}, 32'd1);
    rd_check("auto_reload", A_COUNT, 32'd3);
    wr(A_STATUS, 32'd1);
    rd_check("w1c_idle", A_STATUS, 32'd0);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    repeat (10) @(posedge clk);
    rd_check("auto2_pre", A_STATUS, 32'd0);
    @(posedge clk);
    rd_check("auto2_exp", A_STATUS, 32'd1);
    repeat (11) @(posedge clk);
    wr(A_STATUS, 32'd1);
    rd_check("w1c_vs_exp", A_STATUS, 32'd1);
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);

    // One-shot from COUNT=2: expiry after 8 cycles, then stopped at 0.
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'd1);
    repeat (7) @(posedge clk);
    rd_check("os_pre", A_STATUS, 32'd0);
    @(posedge clk);
    rd_check("os_exp", A_STATUS, 32'd1);
    rd_check("os_count", A_COUNT, 32'd0);
    rd_check("os_ctrl", A_CTRL, 32'd0);
    check("os_irq", {31'd0, irq}, 32'd0);
    repeat (8) @(posedge clk);
    rd_check("os_hold", A_COUNT, 32'd0);

    // COUNT write coinciding with a tick wins; next tick decrements it.
    wr(A_COUNT, 32'd100);
    wr(A_CTRL, 32'd1);
    repeat (3) @(posedge clk);
    wr(A_COUNT, 32'd10);
    rd_check("cw_tick", A_COUNT, 32'd10);
    repeat (3) @(posedge clk);
    rd_check("cw_hold", A_COUNT, 32'd10);
    @(posedge clk);
    rd_check("cw_dec", A_COUNT, 32'd9);
    wr(A_CTRL, 32'd0);

    // Write outside the window is ignored.
    we = 1'b1; a = 32'h0000_0060; wd = 32'hFFFF_FFFF;
    #1;
    check("oow_sel", {31'd0, sel}, 32'd0);
    check("oow_rd", rd, 32'd0);
    @(posedge clk);
    #1 we = 1'b0; wd = '0;
    rd_check("oow_ctrl", A_CTRL, 32'd0);
    rd_check("oow_count", A_COUNT, 32'd9);
    rd_check("oow_load", A_LOAD, 32'd3);
    a = 32'h0000_010C;
    #1 check("win_sel", {31'd0, sel}, 32'd1);

    // Reset mid-run.
    wr(A_CTRL, 32'd4);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'd5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rd_check("mr_ctrl", A_CTRL, 32'd0);
    rd_check("mr_load", A_LOAD, 32'd0);
    rd_check("mr_count", A_COUNT, 32'd0);
    check("mr_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd_check("mr_status", A_STATUS, 32'd0);
    repeat (6) @(posedge clk);
    rd_check("mr_after_count", A_COUNT, 32'd0);
    rd_check("mr_after_ctrl", A_CTRL, 32'd0);
    check("mr_after_irq", {31'd0, irq}, 32'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
